// File: rtl/rel_mem_accumulator_pkg.sv
// Shared types and constants for the spatial-unroll psum accumulator.
// RMA_PSUM_SAT_EN selects saturating column sums instead of wrapping.
package rel_mem_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RMA_ROW    = 16;
  localparam int RMA_COL    = 16;
  localparam int RMA_DW     = 16;
  localparam int RMA_GBF_DW = 512;
  localparam int RMA_RF_AW  = 2;
  localparam int RMA_DEPTH  = 32;
  localparam int RMA_NRF    = 1 << RMA_RF_AW;
  localparam int RMA_SUM_W  = RMA_DW + $clog2(RMA_ROW);
  localparam int RMA_ADDR_W = 10;

  // Low bit of element idx in a vector of w-bit elements.
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rel_mem_col_adder.sv
// Signed reduction of ROW psums into one column sum.
// Wraps by default; saturates when RMA_PSUM_SAT_EN is defined.
module rel_mem_col_adder
  import rel_mem_accumulator_pkg::*;
#(
  parameter int ROW           = RMA_ROW,
  parameter int DATA_BITWIDTH = RMA_DW
) (
  input  logic [ROW*DATA_BITWIDTH-1:0] col,
  output logic [DATA_BITWIDTH-1:0]     sum
);

  localparam int DW = DATA_BITWIDTH;
  localparam int SW = DW + $clog2(ROW);

  logic signed [SW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int r = 0; r < ROW; r++) begin
      acc = acc + SW'($signed(col[lane_lo(r, DW) +: DW]));
    end
  end

`ifdef RMA_PSUM_SAT_EN
  localparam logic signed [SW-1:0] SMAX =
    {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    sum = acc[DW-1:0];
    if (acc > SMAX) begin
      sum = SMAX[DW-1:0];
    end else if (acc < SMIN) begin
      sum = SMIN[DW-1:0];
    end
  end
`else
  assign sum = acc[DW-1:0];
`endif

endmodule

// File: rtl/rel_mem_accumulator.sv
// Sums ROW PE psums per column for each psum RF entry, writes packed words.
// Build with RMA_PSUM_SAT_EN for saturating column sums.
module rel_mem_accumulator
  import rel_mem_accumulator_pkg::*;
#(
  parameter int ROW                   = RMA_ROW,
  parameter int COL                   = RMA_COL,
  parameter int DATA_BITWIDTH         = RMA_DW,
  parameter int GBF_DATA_BITWIDTH     = RMA_GBF_DW,
  parameter int PSUM_RF_ADDR_BITWIDTH = RMA_RF_AW,
  parameter int DEPTH                 = RMA_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
  input  logic                                 pe_psum_finish,
  input  logic                                 conv_finish,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
  output logic                                 su_add_finish,
  output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
  output logic                                 psum_write_en,
  output logic [RMA_ADDR_W-1:0]                psum_BRAM_addr
);

  localparam int DW  = DATA_BITWIDTH;
  localparam int KW  = PSUM_RF_ADDR_BITWIDTH;
  localparam int NRF = 1 << KW;

  typedef logic [KW-1:0]         k_t;
  typedef logic [RMA_ADDR_W-1:0] addr_t;

  function automatic addr_t wrap(input int a);
    return addr_t'(a % DEPTH);
  endfunction

  state_t state;
  state_t state_d;
  k_t     k;
  addr_t  base;
  logic   pend;
  logic   fin_q;
  logic   rise;
  logic   last;

  logic [COL-1:0][ROW*DW-1:0] cols;
  logic [COL-1:0][DW-1:0]     sums;
  logic [GBF_DATA_BITWIDTH-1:0] word;

  assign rise = pe_psum_finish & ~fin_q;
  assign last = (k == k_t'(NRF - 1));

  assign psum_rf_addr = (state == ADD) ? k : '0;

  // Regroup the PE-major psum bus into one ROW-deep vector per column.
  for (genvar c = 0; c < COL; c++) begin : g_col
    for (genvar r = 0; r < ROW; r++) begin : g_row
      assign cols[c][lane_lo(r, DW) +: DW] =
        psum_out[lane_lo(r*COL + c, DW) +: DW];
    end
    rel_mem_col_adder #(
      .ROW           (ROW),
      .DATA_BITWIDTH (DW)
    ) u_add (
      .col (cols[c]),
      .sum (sums[c])
    );
  end

  always_comb begin
    word = '0;
    word[COL*DW-1:0] = sums;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (rise) state_d = ADD;
      ADD:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      k              <= '0;
      base           <= '0;
      pend           <= 1'b0;
      fin_q          <= 1'b0;
      su_add_finish  <= 1'b0;
      out_data       <= '0;
      psum_write_en  <= 1'b0;
      psum_BRAM_addr <= '0;
    end else begin
      state         <= state_d;
      fin_q         <= pe_psum_finish;
      psum_write_en <= 1'b0;
      su_add_finish <= 1'b0;
      unique case (state)
        IDLE: begin
          k <= '0;
          if (conv_finish) base <= '0;
        end
        ADD: begin
          out_data       <= word;
          psum_write_en  <= 1'b1;
          psum_BRAM_addr <= wrap(int'(base) + int'(k));
          su_add_finish  <= last;
          k              <= k + 1'b1;
          if (conv_finish) pend <= 1'b1;
        end
        DONE: begin
          // A conv end seen mid-pass restarts addressing after this pass.
          base <= (pend || conv_finish) ? '0
                                        : wrap(int'(base) + NRF);
          pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rel_mem_accumulator.sv
// Scoreboard bench for rel_mem_accumulator.
// Expected words come from an independent column-sum model.
module tb_rel_mem_accumulator;

  localparam int ROW = 16;
  localparam int COL = 16;
  localparam int DW  = 16;
  localparam int GW  = 512;
  localparam int NRF = 4;
  localparam int DEP = 32;

  logic               clk;
  logic               reset;
  logic [DW*ROW*COL-1:0] psum_out;
  logic               pe_psum_finish;
  logic               conv_finish;
  logic [1:0]         psum_rf_addr;
  logic               su_add_finish;
  logic [GW-1:0]      out_data;
  logic               psum_write_en;
  logic [9:0]         psum_BRAM_addr;

  rel_mem_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .psum_out       (psum_out),
    .pe_psum_finish (pe_psum_finish),
    .conv_finish    (conv_finish),
    .psum_rf_addr   (psum_rf_addr),
    .su_add_finish  (su_add_finish),
    .out_data       (out_data),
    .psum_write_en  (psum_write_en),
    .psum_BRAM_addr (psum_BRAM_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]    addr;
    logic [GW-1:0] word;
    logic          fin;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   base_m = 0;
  bit   ovf = 1'b0;
  bit   mon_en = 1'b0;
  int   l15 [16] = '{7,2,8,7,7,6,2,5,7,4,2,3,7,2,2,1};

  task automatic chk(input string tag,
                     input logic [GW-1:0] got,
                     input logic [GW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int r, input int c,
                                        input int k, input bit o);
    if (o) return 16'h7FFF;
    if (c == 0) return ((r % 4 == 0) || (r % 4 == 3)) ? 16'd4 : 16'd5;
    if (c == 15) return 16'(l15[r]);
    if (c == 7) return 16'(k * (r + 1));
    return 16'(r - c);
  endfunction

  function automatic logic [GW-1:0] exp_word(input int k, input bit o);
    logic [GW-1:0] w;
    w = '0;
    for (int c = 0; c < COL; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < ROW; r++) s += int'($signed(pat(r, c, k, o)));
`ifdef RMA_PSUM_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      w[c*DW +: DW] = 16'(s);
    end
    return w;
  endfunction

  always_comb begin
    psum_out = '0;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        psum_out[(r*COL + c)*DW +: DW] = pat(r, c, int'(psum_rf_addr), ovf);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (psum_write_en) begin
        if (sb.size() == 0) begin
          chk("spurious_we", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("addr", psum_BRAM_addr, e.addr);
          chk("data", out_data, e.word);
          chk("fin", su_add_finish, e.fin);
        end
      end else if (su_add_finish) begin
        chk("fin_stray", 1, 0);
      end
    end
  end

  // conv_mode: 0 none, 1 pulse during ADD, 2 together with the rise in IDLE
  task automatic run_pass(input int conv_mode, input int hold);
    bit seen;
    @(negedge clk);
    if (conv_mode == 2) begin
      base_m = 0;
      conv_finish = 1'b1;
    end
    for (int k = 0; k < NRF; k++) begin
      exp_t e;
      e.addr = 10'((base_m + k) % DEP);
      e.word = exp_word(k, ovf);
      e.fin  = (k == NRF - 1);
      sb.push_back(e);
    end
    pe_psum_finish = 1'b1;
    @(negedge clk);
    conv_finish = 1'b0;
    if (conv_mode == 1) begin
      conv_finish = 1'b1;
      @(negedge clk);
      conv_finish = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (su_add_finish) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pass_done", seen, 1);
    base_m = (conv_mode == 1) ? 0 : (base_m + NRF) % DEP;
    repeat (hold) @(negedge clk);
    pe_psum_finish = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    pe_psum_finish = 1'b0;
    conv_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", psum_write_en, 0);
    chk("rst_fin", su_add_finish, 0);
    chk("rst_addr", psum_BRAM_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rf", psum_rf_addr, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    run_pass(0, 10);
    run_pass(1, 0);
    run_pass(0, 0);
    for (int p = 0; p < 8; p++) run_pass(0, 0);
    chk("wrap_base", base_m, 4);
    ovf = 1'b1;
    run_pass(0, 0);
    ovf = 1'b0;
    run_pass(2, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
